mult_div_unit: RTL and testbench

//  Iterative 32-bit multiply/divide unit with HI/LO result registers for the single-cycle MIPS core.

---
 rtl/mult_div_unit_if.sv | 25 ++
 rtl/mult_div_unit.sv | 132 +++++++++++++
 tb/tb_mult_div_unit.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/mult_div_unit_if.sv
// mult_div_unit_if: core-side issue, HI/LO write and result bundle for mult_div_unit
interface mult_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] operand_a;
    logic [WIDTH-1:0] operand_b;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wr_data;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    modport master (
        output start, op, operand_a, operand_b, hi_we, lo_we, wr_data,
        input  busy, done, div_by_zero, hi, lo
    );
    modport slave (
        input  start, op, operand_a, operand_b, hi_we, lo_we, wr_data,
        output busy, done, div_by_zero, hi, lo
    );
endinterface

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers; define MDU_EARLY_OUT_EN for multiply early-out
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic           clk,
    input  logic           reset,
    mult_div_unit_if.slave bus
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam int RW = WIDTH + 1;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;

    logic [1:0]         state;
    logic [CW-1:0]      cnt;
    logic               is_div, neg_q, neg_r, dbz;
    logic [WIDTH-1:0]   a_raw, a_mag, b_mag, quo;
    logic [WIDTH:0]     rem;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   hi_q, lo_q;
    logic               done_q, dbz_q;

    logic               accept, is_signed, sub_ok, last, mul_zero, early_zero;
    logic [WIDTH-1:0]   in_a_mag, in_b_mag, res_hi, res_lo;
    logic [WIDTH:0]     add_sum;
    logic [2*WIDTH-1:0] acc_nxt, acc_step, prod;
    logic [CW-1:0]      cnt_nxt;

    assign accept    = (state == IDLE) && bus.start;
    assign is_signed = ~bus.op[0];
    assign in_a_mag  = (is_signed && bus.operand_a[WIDTH-1]) ? -bus.operand_a : bus.operand_a;
    assign in_b_mag  = (is_signed && bus.operand_b[WIDTH-1]) ? -bus.operand_b : bus.operand_b;
    assign cnt_nxt   = cnt + CW'(1);
    assign last      = cnt_nxt == CW'(WIDTH);
    assign add_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, a_mag};
    assign acc_nxt   = acc[0] ? {add_sum, acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH-1:1]};
    assign sub_ok    = {rem, quo[WIDTH-1]} >= {2'b0, b_mag};
    assign prod      = neg_q ? -acc : acc;
    assign res_hi    = !is_div ? prod[2*WIDTH-1:WIDTH] : dbz ? a_raw : neg_r ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
    assign res_lo    = !is_div ? prod[WIDTH-1:0] : dbz ? '1 : neg_q ? -quo : quo;

`ifdef MDU_EARLY_OUT_EN
    logic [WIDTH-1:0] mplier_left;
    assign mplier_left = acc_nxt[WIDTH-1:0] << cnt_nxt;
    assign mul_zero    = !is_div && (mplier_left == '0);
    assign early_zero  = !bus.op[1] && (bus.operand_b == '0);
    assign acc_step    = mul_zero ? acc_nxt >> (CW'(WIDTH) - cnt_nxt) : acc_nxt;
`else
    assign mul_zero   = 1'b0;
    assign early_zero = 1'b0;
    assign acc_step   = acc_nxt;
`endif

    // sequencing: IDLE -> CALC (WIDTH steps, fewer on multiply early-out) -> FIX -> IDLE
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else if (accept) begin
            state <= early_zero ? FIX : CALC;
            cnt   <= '0;
        end else if (state == CALC) begin
            state <= (last || mul_zero) ? FIX : CALC;
            cnt   <= cnt_nxt;
        end else begin
            state <= IDLE;
        end
    end

    // operand capture at issue, then one shift-add or restoring-divide step per CALC cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            dbz    <= 1'b0;
            a_raw  <= '0;
            a_mag  <= '0;
            b_mag  <= '0;
            acc    <= '0;
            rem    <= '0;
            quo    <= '0;
        end else if (accept) begin
            is_div <= bus.op[1];
            neg_q  <= is_signed && (bus.operand_a[WIDTH-1] ^ bus.operand_b[WIDTH-1]);
            neg_r  <= is_signed && bus.operand_a[WIDTH-1];
            dbz    <= bus.op[1] && (bus.operand_b == '0);
            a_raw  <= bus.operand_a;
            a_mag  <= in_a_mag;
            b_mag  <= in_b_mag;
            acc    <= {{WIDTH{1'b0}}, in_b_mag};
            rem    <= '0;
            quo    <= in_a_mag;
        end else if (state == CALC) begin
            if (is_div) begin
                rem <= sub_ok ? RW'({rem, quo[WIDTH-1]} - {2'b0, b_mag}) : RW'({rem, quo[WIDTH-1]});
                quo <= {quo[WIDTH-2:0], sub_ok};
            end else begin
                acc <= acc_step;
            end
        end
    end

    // HI/LO write-back on FIX exit; MTHI/MTLO only when idle and not issuing
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi_q   <= '0;
            lo_q   <= '0;
            done_q <= 1'b0;
            dbz_q  <= 1'b0;
        end else begin
            done_q <= state == FIX;
            if (state == FIX) begin
                hi_q  <= res_hi;
                lo_q  <= res_lo;
                dbz_q <= dbz;
            end else if (accept) begin
                dbz_q <= 1'b0;
            end else if (state == IDLE) begin
                if (bus.hi_we) hi_q <= bus.wr_data;
                if (bus.lo_we) lo_q <= bus.wr_data;
            end
        end
    end

    assign bus.busy        = state != IDLE;
    assign bus.done        = done_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed and random scoreboard bench for mult_div_unit
module tb_mult_div_unit;
    localparam int W   = 32;
    localparam int LAT = W + 1;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int total = 0;
    int bad = 0;
    exp_t sb[$];
    logic [31:0] cur_hi, cur_lo;

    always #5 clk = ~clk;

    mult_div_unit_if #(.WIDTH(W)) bus ();
    mult_div_unit #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        exp_t e;
        e.dbz = 1'b0;
        if (o == 2'b00) begin
            p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
            e.hi = p[63:32];
            e.lo = p[31:0];
        end else if (o == 2'b01) begin
            p = {32'b0, a} * {32'b0, b};
            e.hi = p[63:32];
            e.lo = p[31:0];
        end else if (b == 32'd0) begin
            e.hi = a;
            e.lo = 32'hFFFFFFFF;
            e.dbz = 1'b1;
        end else if (o == 2'b10 && a == 32'h80000000 && b == 32'hFFFFFFFF) begin
            e.hi = 32'd0;
            e.lo = 32'h80000000;
        end else if (o == 2'b10) begin
            e.lo = $signed(a) / $signed(b);
            e.hi = $signed(a) % $signed(b);
        end else begin
            e.lo = a / b;
            e.hi = a % b;
        end
        return e;
    endfunction

    task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input exp_t e, input bit push);
        bus.start = 1'b1;
        bus.op = o;
        bus.operand_a = a;
        bus.operand_b = b;
        if (push) sb.push_back(e);
        tick();
        bus.start = 1'b0;
        chk("busy_after_issue", bus.busy, 1);
        chk("dbz_cleared_on_start", bus.div_by_zero, 0);
    endtask

    task automatic wait_result(input int n0, input int lat, output int n);
        exp_t e;
        n = n0;
        while (!bus.done && n < 40) begin
            tick();
            n++;
        end
        chk("done_seen", bus.done, 1);
        if (bus.done) begin
            e = sb.pop_front();
            if (lat >= 0) chk("latency", n, lat);
            chk("hi", bus.hi, e.hi);
            chk("lo", bus.lo, e.lo);
            chk("div_by_zero", bus.div_by_zero, e.dbz);
            chk("busy_at_done", bus.busy, 0);
            cur_hi = e.hi;
            cur_lo = e.lo;
        end
    endtask

    initial begin
        int n, lat;
        logic [1:0] o;
        logic [31:0] a, b;
        logic seen;
        bus.start = 1'b0;
        bus.op = 2'b00;
        bus.operand_a = '0;
        bus.operand_b = '0;
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
        bus.wr_data = '0;
        reset = 1'b1;
        #2;
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_dbz", bus.div_by_zero, 0);
        chk("rst_hi", bus.hi, 0);
        chk("rst_lo", bus.lo, 0);
        tick();
        tick();
        reset = 1'b0;
        bus.hi_we = 1'b1;
        bus.lo_we = 1'b1;
        bus.wr_data = 32'h13572468;
        tick();
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
        chk("mthi_mtlo_hi", bus.hi, 32'h13572468);
        chk("mthi_mtlo_lo", bus.lo, 32'h13572468);
        cur_hi = 32'h13572468;
        cur_lo = 32'h13572468;
        launch(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, {32'hFFFFFFFE, 32'h00000001, 1'b0}, 1);
        wait_result(0, LAT, n);
        tick();
        chk("done_one_cycle", bus.done, 0);
        launch(2'b00, 32'hFFFFFFFD, 32'h00000007, {32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0}, 1);
        wait_result(0, -1, n);
`ifdef MDU_EARLY_OUT_EN
        chk("early_out_latency_le4", n <= 4, 1);
`else
        chk("mult_latency", n, LAT);
`endif
        launch(2'b10, 32'hFFFFFFF9, 32'h00000002, {32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0}, 1);
        wait_result(0, LAT, n);
        launch(2'b11, 32'd100, 32'd7, {32'd2, 32'd14, 1'b0}, 1);
        wait_result(0, LAT, n);
        launch(2'b11, 32'h12345678, 32'd0, {32'h12345678, 32'hFFFFFFFF, 1'b1}, 1);
        wait_result(0, LAT, n);
        launch(2'b10, 32'hFFFFFFF9, 32'd0, {32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1}, 1);
        wait_result(0, LAT, n);
        launch(2'b10, 32'h80000000, 32'hFFFFFFFF, {32'h00000000, 32'h80000000, 1'b0}, 1);
        wait_result(0, LAT, n);
        launch(2'b01, 32'h00010000, 32'h00000030, {32'h00000000, 32'h00300000, 1'b0}, 1);
        repeat (4) tick();
        bus.start = 1'b1;
        bus.op = 2'b11;
        bus.operand_a = 32'd99;
        bus.operand_b = 32'd3;
        bus.hi_we = 1'b1;
        bus.wr_data = 32'hFFFF0000;
        tick();
        bus.start = 1'b0;
        bus.hi_we = 1'b0;
        chk("hi_we_busy_ignored", bus.hi, cur_hi);
        lat = LAT;
`ifdef MDU_EARLY_OUT_EN
        lat = -1;
`endif
        wait_result(5, lat, n);
        bus.lo_we = 1'b1;
        bus.wr_data = 32'hDEADBEEF;
        launch(2'b01, 32'd6, 32'd7, {32'd0, 32'd42, 1'b0}, 1);
        bus.lo_we = 1'b0;
        chk("lo_we_dropped_on_start", bus.lo, cur_lo);
        wait_result(0, lat, n);
        for (int i = 0; i < 8; i++) begin
            o = 2'($urandom_range(0, 3));
            a = $urandom;
            b = (i % 3 == 0) ? 32'($urandom_range(0, 20)) : $urandom;
            lat = LAT;
`ifdef MDU_EARLY_OUT_EN
            if (!o[1]) lat = -1;
`endif
            launch(o, a, b, model(o, a, b), 1);
            wait_result(0, lat, n);
        end
        launch(2'b11, 32'd1000, 32'd9, {32'd0, 32'd0, 1'b0}, 0);
        repeat (9) tick();
        #3;
        reset = 1'b1;
        #1;
        chk("abort_busy", bus.busy, 0);
        chk("abort_done", bus.done, 0);
        chk("abort_hi", bus.hi, 0);
        chk("abort_lo", bus.lo, 0);
        tick();
        reset = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            seen = seen | bus.done;
        end
        chk("no_done_after_abort", seen, 0);
        bus.hi_we = 1'b1;
        bus.wr_data = 32'hA5A5A5A5;
        tick();
        bus.hi_we = 1'b0;
        chk("mthi_after_reset", bus.hi, 32'hA5A5A5A5);
        chk("lo_after_reset", bus.lo, 0);
        chk("scoreboard_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
